// File: rtl/shift_deser32_pkg.sv
// Shared types and helpers for the LSB-first serial-to-parallel receiver.
`include "shift_deser_defs.vh"

package shift_deser32_pkg;

    typedef enum logic {
        ST_IDLE  = `S_IDLE,
        ST_SHIFT = `S_SHIFT
    } state_e;

    localparam int DEFAULT_WIDTH = 32;

    // Exact compare so non-power-of-two widths never rely on counter wrap.
    function automatic logic is_last(input int cnt, input int width);
        return cnt == width - 1;
    endfunction

endpackage

// File: rtl/shift_deser32_sipo.sv
// Right-shifting serial-in register: new bits enter at the MSB, one per enabled cycle.
// Latency 1 cycle per bit; synchronous clear has priority over enable.
module sipo_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             s_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sr_q;

    always_ff @(posedge clk) begin
        if (clr_i) begin
            sr_q <= '0;
        end else if (en_i) begin
            sr_q <= {s_i, sr_q[WIDTH-1:1]};
        end
    end

    assign q_o = sr_q;

endmodule

// File: rtl/shift_deser_defs.vh
// State encodings shared by the deserializer package and anything decoding its state.
`ifndef SHIFT_DESER_DEFS_VH
`define SHIFT_DESER_DEFS_VH

`define S_IDLE  1'b0
`define S_SHIFT 1'b1

`endif

// File: rtl/shift_deser32.sv
// LSB-first serial-to-parallel receiver; completed word appears 1 cycle after its last bit.
// Held word waits on p_ready while the next word shifts in; a word completing into a stalled buffer is dropped and flagged.
module shift_deser32 #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_en,
    input  logic             start,
    input  logic             s_in,
    output logic [WIDTH-1:0] p_out,
    output logic             p_valid,
    input  logic             p_ready,
    output logic             busy,
    output logic             overrun,
    input  logic             clr_ovr
);

    import shift_deser32_pkg::*;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] word;
    logic             shift_en;
    logic             last_bit;
    logic             complete;
    logic             accept;
    logic             sr_lsb_unused;

    logic [WIDTH-1:0] p_out_q, p_out_d;
    logic             p_valid_q, p_valid_d;
    logic             ovr_q, ovr_d;

    assign shift_en = bit_en & (start | (state_q == ST_SHIFT));
    assign last_bit = is_last(int'(32'(cnt_q)), WIDTH);
    assign complete = bit_en & ~start & (state_q == ST_SHIFT) & last_bit;
    assign accept   = ~p_valid_q | p_ready;

    sipo_reg #(.WIDTH(WIDTH)) u_sipo (
        .clk   (clk),
        .clr_i (rst),
        .en_i  (shift_en),
        .s_i   (s_in),
        .q_o   (sr)
    );

    // The register's LSB is the bit shifted out as the final bit arrives.
    assign word          = {s_in, sr[WIDTH-1:1]};
    assign sr_lsb_unused = sr[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else if (bit_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_SHIFT;
                        cnt_q   <= CNT_W'(1);
                    end
                end
                ST_SHIFT: begin
                    if (start) begin
                        cnt_q <= CNT_W'(1);
                    end else if (last_bit) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // A drop in the same cycle as clr_ovr leaves overrun set.
    always_comb begin
        p_out_d   = p_out_q;
        p_valid_d = p_valid_q;
        ovr_d     = clr_ovr ? 1'b0 : ovr_q;
        if (complete) begin
            if (accept) begin
                p_out_d   = word;
                p_valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (p_valid_q & p_ready) begin
            p_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_out_q   <= '0;
            p_valid_q <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            p_out_q   <= p_out_d;
            p_valid_q <= p_valid_d;
            ovr_q     <= ovr_d;
        end
    end

    assign p_out   = p_out_q;
    assign p_valid = p_valid_q;
    assign overrun = ovr_q;
    assign busy    = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_shift_deser32.sv
// Bench for shift_deser32: frame-level reference model plus vector table and directed corner sequences.
module tb_shift_deser32;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         bit_en = 1'b0;
    logic         start = 1'b0;
    logic         s_in = 1'b0;
    logic         p_ready = 1'b0;
    logic         clr_ovr = 1'b0;
    logic [W-1:0] p_out;
    logic         p_valid;
    logic         busy;
    logic         overrun;

    always #5 clk = ~clk;

    shift_deser32 #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .bit_en  (bit_en),
        .start   (start),
        .s_in    (s_in),
        .p_out   (p_out),
        .p_valid (p_valid),
        .p_ready (p_ready),
        .busy    (busy),
        .overrun (overrun),
        .clr_ovr (clr_ovr)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: a queue of bits received in the current frame.
    bit           mq[$];
    bit           m_act = 1'b0;
    logic [W-1:0] m_out = '0;
    bit           m_vld = 1'b0;
    bit           m_ovr = 1'b0;
    int           rises = 0;
    bit           prev_vld = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic be, input logic st,
                              input logic si, input logic rdy, input logic clr);
        bit           comp;
        bit           take;
        logic [W-1:0] w;
        comp = 1'b0;
        w    = '0;
        if (r) begin
            mq.delete();
            m_act = 1'b0;
            m_out = '0;
            m_vld = 1'b0;
            m_ovr = 1'b0;
            return;
        end
        take = m_vld && rdy;
        if (be) begin
            if (st) begin
                mq.delete();
                mq.push_back(si);
                m_act = 1'b1;
            end else if (m_act) begin
                mq.push_back(si);
                if (mq.size() == W) begin
                    for (int i = 0; i < W; i++) w[i] = mq[i];
                    comp = 1'b1;
                    mq.delete();
                    m_act = 1'b0;
                end
            end
        end
        if (clr) m_ovr = 1'b0;
        if (comp) begin
            if (!m_vld || rdy) begin
                m_out = w;
                m_vld = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (take) begin
            m_vld = 1'b0;
        end
    endtask

    task automatic step(input logic r, input logic be, input logic st,
                        input logic si, input logic rdy, input logic clr);
        @(negedge clk);
        rst     = r;
        bit_en  = be;
        start   = st;
        s_in    = si;
        p_ready = rdy;
        clr_ovr = clr;
        @(posedge clk);
        model_edge(r, be, st, si, rdy, clr);
        #1;
        chk("p_valid", 64'(p_valid), 64'(m_vld));
        chk("p_out", 64'(p_out), 64'(m_out));
        chk("busy", 64'(busy), 64'(m_act));
        chk("overrun", 64'(overrun), 64'(m_ovr));
        if (p_valid && !prev_vld) rises++;
        prev_vld = p_valid;
    endtask

    task automatic send_word(input logic [W-1:0] word, input logic rdy,
                             input logic rdy_last, input int maxgap);
        for (int i = 0; i < W; i++) begin
            int gaps;
            gaps = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
            for (int g = 0; g < gaps; g++) step(1'b0, 1'b0, 1'b0, 1'($urandom), rdy, 1'b0);
            step(1'b0, 1'b1, (i == 0), word[i], (i == W - 1) ? rdy_last : rdy, 1'b0);
        end
    endtask

    typedef struct {
        logic [W-1:0] word;
        logic         rdy;
        int           gap;
        logic [W-1:0] exp_out;
        logic         exp_vld;
        logic         exp_ovr;
        logic         idle_rdy;
        logic         exp_vld_after;
    } vec_t;

    vec_t tbl[4];

    initial begin
        tbl[0] = '{32'hDEADBEEF, 1'b1, 0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{32'hDEADBEEF, 1'b1, 3, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{32'h12345678, 1'b0, 0, 32'h12345678, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{32'hCAFEF00D, 1'b0, 1, 32'h12345678, 1'b1, 1'b1, 1'b0, 1'b1};

        // Reset state
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_p_out", 64'(p_out), 64'h0);
        chk("rst_p_valid", 64'(p_valid), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_overrun", 64'(overrun), 64'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            send_word(tbl[i].word, tbl[i].rdy, tbl[i].rdy, tbl[i].gap);
            chk("tbl_p_out", 64'(p_out), 64'(tbl[i].exp_out));
            chk("tbl_p_valid", 64'(p_valid), 64'(tbl[i].exp_vld));
            chk("tbl_overrun", 64'(overrun), 64'(tbl[i].exp_ovr));
            chk("tbl_busy_done", 64'(busy), 64'h0);
            step(1'b0, 1'b0, 1'b0, 1'b0, tbl[i].idle_rdy, 1'b0);
            chk("tbl_vld_after", 64'(p_valid), 64'(tbl[i].exp_vld_after));
        end

        // Clear overrun, then drain the held word
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("clr_ovr", 64'(overrun), 64'h0);
        chk("clr_keeps_word", 64'(p_out), 64'h12345678);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("drain_vld", 64'(p_valid), 64'h0);

        // Completion in the same cycle the held word is accepted
        send_word(32'hA5A5A5A5, 1'b0, 1'b0, 0);
        chk("held_a5", 64'(p_out), 64'hA5A5A5A5);
        send_word(32'h0F0F0F0F, 1'b0, 1'b1, 1);
        chk("swap_p_out", 64'(p_out), 64'h0F0F0F0F);
        chk("swap_p_valid", 64'(p_valid), 64'h1);
        chk("swap_overrun", 64'(overrun), 64'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Resync after 10 bits of a partial frame
        rises = 0;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, (i == 0), 1'($urandom), 1'b1, 1'b0);
        chk("resync_busy", 64'(busy), 64'h1);
        send_word(32'h00000001, 1'b1, 1'b1, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("resync_p_out", 64'(p_out), 64'h1);
        chk("resync_pulses", 64'(rises), 64'h1);
        chk("resync_overrun", 64'(overrun), 64'h0);

        // Reset mid-frame with a held word
        send_word(32'h55AA33CC, 1'b0, 1'b0, 0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, (i == 0), 1'($urandom), 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("midrst_busy", 64'(busy), 64'h0);
        chk("midrst_p_valid", 64'(p_valid), 64'h0);
        chk("midrst_p_out", 64'(p_out), 64'h0);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0, 1'($urandom), 1'b1, 1'b0);
        chk("nostart_busy", 64'(busy), 64'h0);
        chk("nostart_p_valid", 64'(p_valid), 64'h0);
        send_word(32'hFFFFFFFF, 1'b0, 1'b0, 0);
        chk("ones_p_out", 64'(p_out), 64'hFFFFFFFF);
        chk("ones_p_valid", 64'(p_valid), 64'h1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Random whole frames with random backpressure
        for (int f = 0; f < 40; f++) begin
            send_word($urandom, 1'($urandom), 1'($urandom), 2);
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'($urandom), 1'(($urandom % 4) == 0));
        end

        // Fully random per-cycle stimulus
        for (int c = 0; c < 2500; c++) begin
            step(1'(($urandom % 1500) == 0),
                 1'(($urandom % 4) != 0),
                 1'(($urandom % 45) == 0),
                 1'($urandom),
                 1'(($urandom % 3) != 0),
                 1'(($urandom % 30) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_deser32.md
Name: shift_deser32

Overview:
- Serial-to-parallel receiver: the receive end of the team's right-shifting 32-bit parallel-load shift register link.
- Transmit side emits bit 0 first (LSB-first). This block shifts bits in at the MSB and shifts right, so after WIDTH bits the first-received bit sits at bit 0.
- Completed words are held in a separate output register and presented with a valid/ready handshake. Reception of the next word continues while the current word waits.
- Sits between a serial link and any parallel consumer (register file, bus bridge).

Parameters:
- WIDTH, 32, word length in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, do not override.

Ports:
- clk  input  1  single clock, all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- bit_en  input  1  s_in carries a valid bit this cycle.
- start  input  1  qualified by bit_en: this bit is bit 0 of a new word.
- s_in  input  1  serial data bit.
- p_out  output  WIDTH  completed word; stable while p_valid=1.
- p_valid  output  1  p_out holds an unconsumed word.
- p_ready  input  1  consumer accepts p_out when p_valid & p_ready.
- busy  output  1  a word is partially received (state SHIFT).
- overrun  output  1  sticky: a completed word was dropped.
- clr_ovr  input  1  clears overrun.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, bit count=0, shift reg=0.
  - p_out=0, p_valid=0, busy=0, overrun=0.
  - Reset mid-frame discards the partial word and any held word.
- State IDLE:
  - bit_en & start: sr <= {s_in, sr[WIDTH-1:1]}, cnt <= 1, go to SHIFT.
  - bit_en & ~start: ignored; no state change.
- State SHIFT (busy=1):
  - bit_en & ~start: shift, cnt <= cnt+1.
  - bit_en & start: resync. Partial word discarded; this bit becomes bit 0; cnt <= 1; stay in SHIFT; no overrun.
  - ~bit_en: hold all state. There is no timeout.
- Word completion (bit_en in SHIFT with cnt==WIDTH-1 and start=0):
  - Assembled word W = {s_in, sr[WIDTH-1:1]}; state goes to IDLE, cnt <= 0.
  - If p_valid=0, or p_valid & p_ready this cycle: p_out <= W, p_valid <= 1.
  - Otherwise W is dropped, p_out is unchanged, and overrun <= 1.
- Latency: p_valid rises the cycle after the edge that samples the last bit (1 cycle).
- Handshake:
  - p_valid & p_ready with no completion this cycle: p_valid <= 0; p_out keeps its last value.
  - p_out and p_valid never change while p_valid=1 & p_ready=0, except at reset.
  - p_ready is ignored while p_valid=0.
- Overrun:
  - Set only by a dropped word; cleared by clr_ovr or rst.
  - If set and clr_ovr fire in the same cycle, set wins (overrun stays 1).
- Bit counter: cnt never exceeds WIDTH-1. After a completion, the next bit with start=0 is ignored (state is IDLE).
- WIDTH not a power of two: cnt compare is exact (==WIDTH-1), with no wrap reliance.

Decomposition:
- Shared header `shift_deser_defs.vh` (include-guarded): state encodings S_IDLE=1'b0, S_SHIFT=1'b1.
- One natural sub-module, sipo_reg: WIDTH-bit right-shifting serial-in register with enable and synchronous clear.
- The FSM, counter, output buffer and overrun logic stay in shift_deser32.

Test Plan:
- 0xDEADBEEF sent LSB-first: 32 consecutive bit_en, start on the first bit, p_ready=1 → p_out=0xDEADBEEF, p_valid high exactly 1 cycle, overrun=0.
- Same word with bit_en idle gaps of 0–3 random cycles between bits → same p_out. busy=1 from first bit until completion, then 0.
- p_ready=0: send 0x12345678 then 0xCAFEF00D → p_out stays 0x12345678, overrun=1 after the second completion. clr_ovr pulse → overrun=0.
- Word 0xA5A5A5A5 held with p_ready=0; second word 0x0F0F0F0F completes in the same cycle p_ready=1 → p_out=0x0F0F0F0F, p_valid stays 1, overrun=0.
- Resync: send 10 bits, then start on bit 11 followed by a full 0x00000001 frame → p_out=0x00000001, exactly one p_valid pulse, overrun=0.
- Reset edge cases:
  - rst asserted after 20 bits → busy=0, p_valid=0.
  - 12 bits without start are ignored.
  - A subsequent full 0xFFFFFFFF frame → p_out=0xFFFFFFFF.
